// File: rtl/spi_io_pkg.sv
// Shared definitions for the guest-side SPI IO responder: command codes,
// FSM state encoding and keyboard buffer sizing.
package spi_io_pkg;

   // Command byte codes sent by the MCU in the first byte of a transfer
   localparam logic [7:0] CMD_BUT_SW = 8'h01;
   localparam logic [7:0] CMD_JOY0   = 8'h02;
   localparam logic [7:0] CMD_JOY1   = 8'h03;
   localparam logic [7:0] CMD_KBD    = 8'h05;
   localparam logic [7:0] CMD_STATUS = 8'h1E;

   // Keyboard buffer depth when the FIFO variant is built
   localparam int unsigned KBD_FIFO_DEPTH = 8;

   // Transfer FSM state encoding
   typedef logic [1:0] spi_io_state_t;
   localparam spi_io_state_t ST_IDLE          = 2'd0;
   localparam spi_io_state_t ST_CMD           = 2'd1;
   localparam spi_io_state_t ST_PAYLOAD       = 2'd2;
   localparam spi_io_state_t ST_WAIT_DESELECT = 2'd3;

endpackage

// File: rtl/spi_io_fifo.sv
// Generic synchronous valid/ready FIFO. A push into a full FIFO is still
// accepted when a pop happens in the same cycle.
module spi_io_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             push;
   logic             pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign out_valid = (count_q != '0);
   assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
   assign pop       = out_valid & out_ready;
   assign in_ready  = (count_q != CW'(DEPTH)) | out_ready;
   assign push      = in_valid & in_ready;

   // Pointer and occupancy tracking
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push && !pop)      count_q <= count_q + CW'(1);
         else if (pop && !push) count_q <= count_q - CW'(1);
      end
   end

   // Storage array; contents are only observed while out_valid is high
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= in_data;
   end

endmodule

// File: rtl/spi_io_responder.sv
// Guest-side SPI mode-0 responder for the MCU configuration/IO channel.
// Decodes command-framed transfers into buttons, switches, joysticks, a
// status word and a keyboard byte stream; returns CORE_TYPE during the
// command byte.
// Build option: SPI_IO_KBD_FIFO_EN selects an 8-entry keyboard FIFO instead
// of a single holding register.
module spi_io_responder
   import spi_io_pkg::*;
#(
   parameter logic [7:0]  CORE_TYPE   = 8'hA4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        spi_sck,
   input  logic        spi_ss_n,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        spi_miso_oe,
   output logic [1:0]  buttons,
   output logic [1:0]  switches,
   output logic [7:0]  joystick_0,
   output logic [7:0]  joystick_1,
   output logic [31:0] status,
   output logic [7:0]  kbd_data,
   output logic        kbd_valid,
   input  logic        kbd_ready,
   output logic        kbd_ovf
);

   logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
   logic                   sck_prev, ss_prev;
   logic                   sck_s, ss_s, mosi_s;
   logic                   sck_rise, sck_fall;

   spi_io_state_t state_q;
   logic [2:0]    bit_cnt_q;
   logic [6:0]    shift_q;
   logic [7:0]    tx_q;
   logic [7:0]    cmd_q;
   logic [2:0]    pidx_q;
   logic [23:0]   shadow_q;
   logic [7:0]    rx_byte;
   logic          pay_done;
   logic          kbd_push;

   // Synchronizers are left unreset so ss_n is tracked through reset; this
   // lets a release with ss_n already low land in WAIT_DESELECT.
   always_ff @(posedge clk) begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_prev  <= sck_sync[SYNC_STAGES-1];
      ss_prev   <= ss_sync[SYNC_STAGES-1];
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign ss_s     = ss_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev;
   assign sck_fall = ~sck_s & sck_prev;
   assign rx_byte  = {shift_q, mosi_s};
   assign pay_done = (state_q == ST_PAYLOAD) & ~ss_s & sck_rise & (bit_cnt_q == 3'd7);
   assign kbd_push = pay_done & (cmd_q == CMD_KBD);

   assign spi_miso    = (state_q == ST_CMD) & tx_q[7];
   assign spi_miso_oe = ~ss_s & ((state_q == ST_CMD) | (state_q == ST_PAYLOAD));

   // Transfer FSM, receive shifter and command-byte MISO shifter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= 3'd0;
         shift_q   <= 7'd0;
         tx_q      <= 8'd0;
         cmd_q     <= 8'd0;
         pidx_q    <= 3'd0;
      end else if (ss_s) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= 3'd0;
         pidx_q    <= 3'd0;
      end else begin
         case (state_q)
            // ss_n low without a seen falling edge only happens after reset
            ST_IDLE: begin
               if (ss_prev) begin
                  state_q   <= ST_CMD;
                  tx_q      <= CORE_TYPE;
                  bit_cnt_q <= 3'd0;
               end else begin
                  state_q <= ST_WAIT_DESELECT;
               end
            end
            ST_CMD: begin
               if (sck_rise) begin
                  shift_q   <= rx_byte[6:0];
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     cmd_q   <= rx_byte;
                     pidx_q  <= 3'd0;
                     state_q <= ST_PAYLOAD;
                  end
               end else if (sck_fall) begin
                  tx_q <= {tx_q[6:0], 1'b0};
               end
            end
            ST_PAYLOAD: begin
               if (sck_rise) begin
                  shift_q   <= rx_byte[6:0];
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7 && pidx_q != 3'd7) pidx_q <= pidx_q + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Payload decode into the core-facing registers
   always_ff @(posedge clk) begin
      if (reset) begin
         buttons    <= 2'd0;
         switches   <= 2'd0;
         joystick_0 <= 8'd0;
         joystick_1 <= 8'd0;
         status     <= 32'd0;
         shadow_q   <= 24'd0;
      end else if (pay_done) begin
         case (cmd_q)
            CMD_BUT_SW: begin
               if (pidx_q == 3'd0) begin
                  buttons  <= rx_byte[1:0];
                  switches <= rx_byte[3:2];
               end
            end
            CMD_JOY0: if (pidx_q == 3'd0) joystick_0 <= rx_byte;
            CMD_JOY1: if (pidx_q == 3'd0) joystick_1 <= rx_byte;
            // Status commits only when the fourth byte completes
            CMD_STATUS: begin
               case (pidx_q)
                  3'd0:    shadow_q[7:0]   <= rx_byte;
                  3'd1:    shadow_q[15:8]  <= rx_byte;
                  3'd2:    shadow_q[23:16] <= rx_byte;
                  3'd3:    status          <= {rx_byte, shadow_q};
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

`ifdef SPI_IO_KBD_FIFO_EN
   logic kbd_in_ready;

   spi_io_fifo #(
      .WIDTH (8),
      .DEPTH (KBD_FIFO_DEPTH)
   ) u_kbd_fifo (
      .clk       (clk),
      .reset     (reset),
      .in_data   (rx_byte),
      .in_valid  (kbd_push),
      .in_ready  (kbd_in_ready),
      .out_data  (kbd_data),
      .out_valid (kbd_valid),
      .out_ready (kbd_ready)
   );

   // Overflow pulse when a keyboard byte cannot be stored
   always_ff @(posedge clk) begin
      if (reset) kbd_ovf <= 1'b0;
      else       kbd_ovf <= kbd_push & ~kbd_in_ready;
   end
`else
   // Single holding register; an unpopped byte is overwritten by a new push
   always_ff @(posedge clk) begin
      if (reset) begin
         kbd_data  <= 8'd0;
         kbd_valid <= 1'b0;
         kbd_ovf   <= 1'b0;
      end else begin
         kbd_ovf <= kbd_push & kbd_valid & ~kbd_ready;
         if (kbd_push) begin
            kbd_data  <= rx_byte;
            kbd_valid <= 1'b1;
         end else if (kbd_valid && kbd_ready) begin
            kbd_valid <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: doc/spi_io_responder.md
Name: spi_io_responder

Overview:
- Guest-side SPI responder for the MCU-to-guest configuration/IO channel; the target end of the link that substitute_mcu initiates.
- Select is CONF_DATA0, data in is SPI_DI, data out is SPI_DO.
- Decodes command-framed transfers into core state: buttons, switches, two joysticks, 32-bit status word and a PS/2 keyboard byte stream.
- Returns CORE_TYPE to the MCU during the command byte; sits inside guest_top next to the core.

Parameters:
- CORE_TYPE, 8'hA4, byte shifted out on MISO during every command byte.
- SYNC_STAGES, 2, synchronizer depth for sck/ss_n/mosi (≥2).

Ports:
- clk  in  1  system clock; must be ≥4× spi_sck frequency.
- reset  in  1  synchronous, active-high.
- spi_sck  in  1  SPI clock, mode 0, asynchronous to clk.
- spi_ss_n  in  1  transfer select (CONF_DATA0), active low.
- spi_mosi  in  1  MCU-to-guest data (SPI_DI).
- spi_miso  out  1  guest-to-MCU data (SPI_DO).
- spi_miso_oe  out  1  high while selected; top level tristates spi_miso otherwise.
- buttons  out  2  from cmd 0x01 payload bits[1:0].
- switches  out  2  from cmd 0x01 payload bits[3:2].
- joystick_0  out  8  from cmd 0x02.
- joystick_1  out  8  from cmd 0x03.
- status  out  32  from cmd 0x1E.
- kbd_data  out  8  PS/2 keyboard byte (cmd 0x05).
- kbd_valid  out  1  kbd_data holds an unread byte.
- kbd_ready  in  1  consumer accepts; a byte pops when valid && ready.
- kbd_ovf  out  1  one-cycle pulse when a received keyboard byte is lost.

Behaviour:
- Reset values: all outputs 0; spi_miso_oe=0; FIFO empty; state IDLE.
- Input sync: sck, ss_n and mosi each pass SYNC_STAGES flops. Rise/fall of sck is detected on synced values. Internal latency is SYNC_STAGES+1 clk.
- States:
  - IDLE → CMD on synced ss_n falling.
  - CMD → PAYLOAD after 8 sck rises; cmd register loaded.
  - PAYLOAD stays in PAYLOAD until ss_n high.
  - Any state → IDLE on ss_n high.
  - WAIT_DESELECT: entered when reset releases while ss_n is low; → IDLE only on ss_n high. No bytes are decoded in this state.
- Shifting: mosi sampled on sck rise, MSB first. Byte complete on the 8th rise. Bit counter 3-bit wraps to 0 after each byte.
- MISO:
  - CORE_TYPE[7] is presented within 1 clk of ss_n falling.
  - Next bit is presented on each sck fall during CMD.
  - 0 during PAYLOAD.
  - spi_miso_oe = ~synced ss_n, forced 0 outside CMD/PAYLOAD.
- Payload byte index is 3-bit and saturates at 7.
- Commands:
  - 0x01/0x02/0x03: byte 0 updates the target register; later bytes are ignored.
  - 0x1E: bytes 0..3 (little-endian) go into a shadow register. status updates atomically on completion of byte 3 only.
  - 0x05: every payload byte is pushed to the keyboard buffer.
  - Other codes: payload consumed and discarded, no output change.
- ss_n rising mid-byte: partial byte discarded; a partial 0x1E sequence leaves status unchanged.
- Register outputs update 1 clk after the completing sck rise is detected.
- Keyboard buffer:
  - Push and pop in the same cycle are both honoured.
  - Push when full: byte dropped, kbd_ovf pulses.
- Reset mid-transfer: registers return to reset values; state enters WAIT_DESELECT.

Optional Feature:
- SPI_IO_KBD_FIFO_EN defined: keyboard buffer is an 8-entry FIFO with 3-bit pointers plus full/empty via count. Full = 8 entries.
- Not defined: single holding register. A push while kbd_valid=1 without a simultaneous pop overwrites the held byte and pulses kbd_ovf.

Decomposition:
- Package spi_io_pkg holds:
  - Command constants CMD_BUT_SW=8'h01, CMD_JOY0=8'h02, CMD_JOY1=8'h03, CMD_KBD=8'h05, CMD_STATUS=8'h1E.
  - State enum spi_io_state_t (IDLE, CMD, PAYLOAD, WAIT_DESELECT).
  - KBD_FIFO_DEPTH=8.
- Sub-module spi_io_fifo: generic synchronous valid/ready FIFO, parameterized width/depth. Instantiated only under SPI_IO_KBD_FIFO_EN.

Test Plan:
- Command 0x02 then payload 0x5A, ss_n high → joystick_0=0x5A; MISO bits during command byte read back 0xA4.
- Command 0x1E then bytes 0x78,0x56,0x34,0x12 → status=0x12345678. Second transfer of 0x1E, 0xFF, 0xFF, then ss_n deasserted → status still 0x12345678.
- Command 0x05 then bytes 0x1C,0xF0,0x1C with kbd_ready=0 → FIFO build: 3 entries, kbd_data=0x1C, pops in order when ready=1. Non-FIFO build: kbd_data=0x1C (last), two kbd_ovf pulses.
- FIFO build: 9 keyboard bytes with ready=0 → 9th dropped, one kbd_ovf pulse, 8 bytes read back in order.
- Command 0x01 then byte 0x0F → buttons=2'b11, switches=2'b11. Unknown command 0x77 then byte 0xAA → no output change.
- Assert reset after 3 bits of a 0x02 payload, release with ss_n low, clock 5 more bits → joystick_0 stays 0. After ss_n high and a new 0x02/0x33 transfer → joystick_0=0x33.
